// File: rtl/parity_error_checker.sv
// Parity checker for a DATA_W-bit word (payload + parity bit): registers a per-word
// error flag and keeps sticky and saturating-count error status.
module parity_error_checker #(
  parameter int unsigned DATA_W     = 6,
  parameter bit          ODD_PARITY = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  input  logic              clr,
  output logic              error,
  output logic              out_valid,
  output logic              sticky_error,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             error_now;
  logic             flagged;
  logic             error_d,     error_q;
  logic             out_valid_d, out_valid_q;
  logic             sticky_d,    sticky_q;
  logic [CNT_W-1:0] cnt_d,       cnt_q;

  assign error_now = (^data) ^ ODD_PARITY;

  always_comb begin
    error_d     = error_q;
    out_valid_d = data_valid;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    flagged     = 1'b0;

    // Gate on data_valid first so an unknown data bus cannot leak into state.
    if (data_valid) begin
      error_d = error_now;
      flagged = error_now;
    end

    if (flagged) begin
      sticky_d = 1'b1;
      if (clr)
        cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX)
        cnt_d = cnt_q + CNT_W'(1);
    end else if (clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q     <= 1'b0;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      error_q     <= error_d;
      out_valid_q <= out_valid_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign error        = error_q;
  assign out_valid    = out_valid_q;
  assign sticky_error = sticky_q;
  assign err_count    = cnt_q;

endmodule

// File: tb/tb_parity_error_checker.sv
// Self-checking bench: even- and odd-parity builds side by side, a directed vector
// table, hand-written reset/saturation sequences and random stimulus vs a model.
module tb_parity_error_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] data = '0;
  logic       data_valid = 1'b0;
  logic       clr = 1'b0;

  logic       error_e, out_valid_e, sticky_e;
  logic [7:0] cnt_e;
  logic       error_o, out_valid_o, sticky_o;
  logic [7:0] cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  parity_error_checker #(.DATA_W(6), .ODD_PARITY(1'b0), .CNT_W(8)) dut_even (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid), .clr(clr),
    .error(error_e), .out_valid(out_valid_e), .sticky_error(sticky_e), .err_count(cnt_e)
  );

  parity_error_checker #(.DATA_W(6), .ODD_PARITY(1'b1), .CNT_W(8)) dut_odd (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid), .clr(clr),
    .error(error_o), .out_valid(out_valid_o), .sticky_error(sticky_o), .err_count(cnt_o)
  );

  // Reference model, index 0 = even build, 1 = odd build.
  bit m_err[2];
  bit m_ov;
  bit m_sticky[2];
  int m_cnt[2];

  task automatic model_reset();
    m_ov = 0;
    for (int p = 0; p < 2; p++) begin
      m_err[p] = 0; m_sticky[p] = 0; m_cnt[p] = 0;
    end
  endtask

  task automatic model_edge(input logic [5:0] d, input bit v, input bit c);
    bit e;
    m_ov = v;
    for (int p = 0; p < 2; p++) begin
      e = 0;
      if (v) begin
        // Error when the ones-count parity disagrees with the selected mode.
        e = (($countones(d) % 2) == 1) != (p == 1);
        m_err[p] = e;
      end
      if (e) begin
        m_sticky[p] = 1;
        m_cnt[p] = c ? 1 : ((m_cnt[p] + 1 > 255) ? 255 : m_cnt[p] + 1);
      end else if (c) begin
        m_sticky[p] = 0;
        m_cnt[p] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("even.error",     32'(error_e),     32'(m_err[0]));
    chk("even.out_valid", 32'(out_valid_e), 32'(m_ov));
    chk("even.sticky",    32'(sticky_e),    32'(m_sticky[0]));
    chk("even.count",     32'(cnt_e),       32'(m_cnt[0]));
    chk("odd.error",      32'(error_o),     32'(m_err[1]));
    chk("odd.out_valid",  32'(out_valid_o), 32'(m_ov));
    chk("odd.sticky",     32'(sticky_o),    32'(m_sticky[1]));
    chk("odd.count",      32'(cnt_o),       32'(m_cnt[1]));
  endtask

  task automatic cycle(input logic [5:0] d, input bit v, input bit c);
    data = d; data_valid = v; clr = c;
    @(posedge clk);
    model_edge(d, v, c);
    #1;
    chk_model();
  endtask

  typedef struct {
    logic [5:0] d;
    bit         v;
    bit         c;
    bit         exp_err;
    bit         exp_ov;
    logic [7:0] exp_cnt;
    bit         exp_sticky;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{6'b000000, 1, 0, 0, 1, 8'd0, 0});
    vecs.push_back('{6'b100001, 1, 0, 0, 1, 8'd0, 0});
    vecs.push_back('{6'b100001, 1, 0, 0, 1, 8'd0, 0});
    vecs.push_back('{6'b000011, 1, 0, 0, 1, 8'd0, 0});
    vecs.push_back('{6'b000111, 1, 0, 1, 1, 8'd1, 1});
    vecs.push_back('{6'b000000, 0, 0, 1, 0, 8'd1, 1});
    vecs.push_back('{6'b000111, 1, 0, 1, 1, 8'd2, 1});
    vecs.push_back('{6'b000111, 1, 1, 1, 1, 8'd1, 1});
    vecs.push_back('{6'b000111, 1, 0, 1, 1, 8'd2, 1});
    vecs.push_back('{6'b000000, 0, 1, 1, 0, 8'd0, 0});
    vecs.push_back('{6'bxxxxxx, 0, 0, 1, 0, 8'd0, 0});

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.error",     32'(error_e),     32'd0);
    chk("reset.out_valid", 32'(out_valid_e), 32'd0);
    chk("reset.sticky",    32'(sticky_e),    32'd0);
    chk("reset.count",     32'(cnt_e),       32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].d, vecs[i].v, vecs[i].c);
      chk($sformatf("vec%0d.error", i),     32'(error_e),     32'(vecs[i].exp_err));
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid_e), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d.count", i),     32'(cnt_e),       32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d.sticky", i),    32'(sticky_e),    32'(vecs[i].exp_sticky));
      chk($sformatf("vec%0d.x_free", i),    32'($isunknown({error_e, out_valid_e, sticky_e, cnt_e})), 32'd0);
    end

    // Saturation: more than 2^CNT_W consecutive flagged words.
    cycle(6'b000000, 0, 1);
    for (int i = 0; i < 300; i++) cycle(6'b000001, 1, 0);
    chk("sat.count", 32'(cnt_e), 32'd255);
    chk("sat.sticky", 32'(sticky_e), 32'd1);

    // Odd-parity build on directed words.
    cycle(6'b000000, 1, 0);
    chk("odd.zero_word", 32'(error_o), 32'd1);
    cycle(6'b000111, 1, 0);
    chk("odd.three_ones", 32'(error_o), 32'd0);

    // Asynchronous reset mid-stream with count at 5.
    cycle(6'b000000, 0, 1);
    for (int i = 0; i < 5; i++) cycle(6'b010000, 1, 0);
    chk("pre_rst.count", 32'(cnt_e), 32'd5);
    data = 6'b010000; data_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst.error",     32'(error_e),     32'd0);
    chk("async_rst.out_valid", 32'(out_valid_e), 32'd0);
    chk("async_rst.sticky",    32'(sticky_e),    32'd0);
    chk("async_rst.count",     32'(cnt_e),       32'd0);
    chk("async_rst.odd_error", 32'(error_o),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle(6'b110100, 1, 0);
    chk("post_rst.error", 32'(error_e), 32'd1);
    chk("post_rst.count", 32'(cnt_e),   32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      logic [5:0] d;
      d = 6'($urandom);
      cycle(d, ($urandom_range(3) != 0), ($urandom_range(15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parity_error_checker.md
Name: parity_error_checker

Overview:
- Checks a 6-bit word (5 payload bits + 1 parity bit) for a parity error in the healthcare-system datapath.
- Computes the XOR of all bits, registers a per-word error flag, and keeps sticky and counted error status for the downstream controller.
- One clock; the registered result is valid one cycle after the input word.

Parameters:
- DATA_W, 6, width of the checked word including its parity bit.
- ODD_PARITY, 0. 0 selects even parity: a valid word has an even number of ones. 1 selects odd parity.
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data  input  DATA_W  word under check: payload plus parity bit.
- data_valid  input  1  qualifies data for the current cycle.
- clr  input  1  synchronous clear of sticky_error and err_count.
- error  output  1  registered parity error for the last accepted word.
- out_valid  output  1  high for one cycle when error reflects a newly accepted word.
- sticky_error  output  1  set on any flagged word since the last rst or clr.
- err_count  output  CNT_W  number of flagged words, saturating.

Behaviour:
- Parity and error detection:
  - parity = XOR reduction of all DATA_W bits of data.
  - error_now = parity XOR ODD_PARITY.
  - With ODD_PARITY=0, error_now=1 exactly when data has an odd number of ones.
- Reset: while rst is high, asynchronously force error=0, out_valid=0, sticky_error=0, err_count=0. Reset asserted mid-stream discards any in-flight word. The first word accepted after rst falls is processed normally.
- Accepted word (rising edge with data_valid=1):
  - error <= error_now and out_valid <= 1 (latency 1 cycle).
  - The same word may be presented on consecutive cycles; each presentation is checked and counted independently.
- Idle cycle (data_valid=0):
  - out_valid <= 0.
  - error holds its last value.
  - sticky_error and err_count unchanged apart from clr.
- sticky_error: set when an accepted word has error_now=1. Stays set until clr or rst.
- err_count: increments by 1 per accepted word with error_now=1. Saturates at 2^CNT_W-1 and never wraps.
- clr (synchronous):
  - Zeroes sticky_error and err_count.
  - If clr and a flagged word coincide, the new word wins: sticky_error=1 and err_count=1 after that edge.
  - clr does not affect error or out_valid.
- The datapath is purely combinational up to the output registers.
- Outputs are never X after reset, even if data is X while data_valid=0.

Test Plan:
- Reset, then data=6'b000000 with data_valid=1 -> next cycle error=0, out_valid=1, err_count=0, sticky_error=0.
- data=6'b100001 presented twice consecutively -> error=0 on both, err_count stays 0.
- data=6'b000011 -> error=0; then data=6'b000111 -> error=1, sticky_error=1, err_count=1.
- data=6'b000111 held with data_valid high while clr is pulsed on one of those cycles -> err_count increments each cycle and becomes 1 on the clr cycle, sticky_error remains 1.
- Drive data=6'b000001 with data_valid=1 for more than 2^CNT_W cycles -> err_count saturates at 8'hFF and does not wrap.
- Assert rst asynchronously mid-stream while err_count=5 -> all outputs 0 immediately. ODD_PARITY=1 build: 6'b000000 -> error=1, 6'b000111 -> error=0.
